// File: rtl/sram_like_pkg.sv
// rtl/sram_like_pkg.sv - shared types and strobe helper for the sram-like responder
package sram_like_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_entry_t;

   localparam int ENTRY_W = $bits(req_entry_t);

   // Misaligned halves/words and the illegal size yield no strobes at all.
   function automatic logic [3:0] gen_strobe(input logic [1:0] sz, input logic [1:0] addr_lo);
      logic [3:0] strb;
      strb = 4'b0000;
      case (sz)
         SIZE_BYTE: strb = 4'b0001 << addr_lo;
         SIZE_HALF: strb = addr_lo[0] ? 4'b0000 : (4'b0011 << {addr_lo[1], 1'b0});
         SIZE_WORD: strb = (addr_lo == 2'b00) ? 4'b1111 : 4'b0000;
         default:   strb = 4'b0000;
      endcase
      return strb;
   endfunction

endpackage

// File: rtl/sram_like_req_fifo.sv
// rtl/sram_like_req_fifo.sv - circular request queue with occupancy count
module sram_like_req_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 67
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= din;
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign dout  = mem[rptr];
   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/sram_like_slave.sv
// rtl/sram_like_slave.sv - sram-like responder: queued requests, wait latency, RAM drive
module sram_like_slave
   import sram_like_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int LATENCY = 0,
   parameter int ADDR_W  = 14
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req,
   input  logic              wr,
   input  logic [1:0]        size,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic              addr_ok,
   output logic              data_ok,
   output logic [31:0]       rdata,
   output logic              ram_en,
   output logic [3:0]        ram_wen,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [3:0] LAT = LATENCY[3:0];

   logic               push;
   logic               pop;
   logic               full;
   logic               empty;
   logic [CW-1:0]      fifo_count;
   logic [ENTRY_W-1:0] head_bits;
   req_entry_t         head;
   req_entry_t         in_entry;
   state_t             state, state_next;
   logic [3:0]         cnt, cnt_next;
   logic               unused_addr_bits;

   // Gated by rstn so no handshake can be seen while reset is held.
   assign addr_ok  = req & ~full & rstn;
   assign push     = addr_ok;
   assign in_entry = '{wr: wr, size: size, addr: addr, wdata: wdata};
   assign head     = req_entry_t'(head_bits);
   assign unused_addr_bits = ^head.addr[31:ADDR_W+2];

   sram_like_req_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push),
      .pop   (pop),
      .din   (in_entry),
      .dout  (head_bits),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      pop        = 1'b0;
      data_ok    = 1'b0;
      rdata      = '0;
      ram_en     = 1'b0;
      ram_wen    = '0;
      ram_addr   = '0;
      ram_wdata  = '0;
      case (state)
         IDLE: begin
            if (!empty) begin
               cnt_next   = LAT;
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (cnt != 4'd0) begin
               cnt_next = cnt - 4'd1;
            end else begin
               ram_en     = 1'b1;
               ram_addr   = head.addr[ADDR_W+1:2];
               ram_wen    = head.wr ? gen_strobe(head.size, head.addr[1:0]) : 4'b0000;
               ram_wdata  = head.wdata;
               state_next = RESP;
            end
         end
         RESP: begin
            data_ok = 1'b1;
            pop     = 1'b1;
            rdata   = head.wr ? 32'h0 : ram_rdata;
            // Another entry is pending if one remains after this pop or arrives now.
            if ((fifo_count > CW'(1)) || push) begin
               cnt_next   = LAT;
               state_next = WAIT;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sram_like_slave.sv
// tb/tb_sram_like_slave.sv - directed bench: instance 0 has LATENCY=0, instance 1 has LATENCY=2
module tb_sram_like_slave;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req       [2];
   logic        wr        [2];
   logic [1:0]  size      [2];
   logic [31:0] addr      [2];
   logic [31:0] wdata     [2];
   logic        addr_ok   [2];
   logic        data_ok   [2];
   logic [31:0] rdata     [2];
   logic        ram_en    [2];
   logic [3:0]  ram_wen   [2];
   logic [9:0]  ram_addr  [2];
   logic [31:0] ram_wdata [2];
   logic [31:0] ram_rdata [2];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [31:0] mem [0:1023];

      initial begin
         for (int i = 0; i < 1024; i++) mem[i] = {16'hC0DE, 16'(i)};
         mem[4] = 32'hDEADBEEF;
      end

      always @(posedge clk) begin
         if (ram_en[g]) begin
            ram_rdata[g] <= mem[ram_addr[g]];
            for (int b = 0; b < 4; b++)
               if (ram_wen[g][b]) mem[ram_addr[g]][8*b +: 8] = ram_wdata[g][8*b +: 8];
         end
      end

      sram_like_slave #(
         .DEPTH   (4),
         .LATENCY ((g == 0) ? 0 : 2),
         .ADDR_W  (10)
      ) u_dut (
         .clk       (clk),
         .rstn      (rstn),
         .req       (req[g]),
         .wr        (wr[g]),
         .size      (size[g]),
         .addr      (addr[g]),
         .wdata     (wdata[g]),
         .addr_ok   (addr_ok[g]),
         .data_ok   (data_ok[g]),
         .rdata     (rdata[g]),
         .ram_en    (ram_en[g]),
         .ram_wen   (ram_wen[g]),
         .ram_addr  (ram_addr[g]),
         .ram_wdata (ram_wdata[g]),
         .ram_rdata (ram_rdata[g])
      );
   end

   // One transaction from an idle slave; cycle numbers are relative to the handshake cycle.
   task automatic run_one(input int d, input logic w, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic hs, output int en_cyc, output int ok_cyc,
                          output logic [3:0] wen_s, output logic [9:0] addr_s,
                          output logic [31:0] wdat_s, output logic [31:0] rdat_s);
      en_cyc = -1;
      ok_cyc = -1;
      wen_s  = 4'hF;
      addr_s = 10'h3FF;
      wdat_s = 32'hFFFFFFFF;
      rdat_s = 32'hFFFFFFFF;
      @(negedge clk);
      req[d] = 1'b1; wr[d] = w; size[d] = sz; addr[d] = a; wdata[d] = wd;
      #1;
      hs = addr_ok[d];
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         req[d] = 1'b0;
         #1;
         if (ram_en[d] && en_cyc < 0) begin
            en_cyc = k; wen_s = ram_wen[d]; addr_s = ram_addr[d]; wdat_s = ram_wdata[d];
         end
         if (data_ok[d] && ok_cyc < 0) begin
            ok_cyc = k; rdat_s = rdata[d];
         end
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      for (int d = 0; d < 2; d++) begin
         req[d] = 1'b1; wr[d] = 1'b0; size[d] = 2'd2; addr[d] = '0; wdata[d] = '0;
      end
      repeat (3) @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({addr_ok[d], data_ok[d], ram_en[d]} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl[%0d]: got %b expected 000", d, {addr_ok[d], data_ok[d], ram_en[d]});
         end
         checks++;
         if ({rdata[d], ram_wen[d], ram_addr[d], ram_wdata[d]} !== 78'h0) begin
            errors++; $display("FAIL reset_data[%0d]: got %h expected 0", d, {rdata[d], ram_wen[d], ram_addr[d], ram_wdata[d]});
         end
      end
      req[0] = 1'b0; req[1] = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({data_ok[0], data_ok[1], ram_en[0], ram_en[1]} !== 4'b0000) begin
         errors++; $display("FAIL post_reset_idle: got %b expected 0000", {data_ok[0], data_ok[1], ram_en[0], ram_en[1]});
      end
   endtask

   task automatic test_word_read();
      logic hs; int en, ok; logic [3:0] wen; logic [9:0] ra; logic [31:0] wd, rd;
      run_one(0, 1'b0, 2'd2, 32'h10, 32'h0, hs, en, ok, wen, ra, wd, rd);
      checks++; if (hs !== 1'b1) begin errors++; $display("FAIL rd_addr_ok: got %b expected 1", hs); end
      checks++; if (en != 2) begin errors++; $display("FAIL rd_en_cycle: got %0d expected 2", en); end
      checks++; if (ok != 3) begin errors++; $display("FAIL rd_ok_cycle: got %0d expected 3", ok); end
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
      checks++; if (ra !== 10'd4) begin errors++; $display("FAIL rd_ram_addr: got %0d expected 4", ra); end
      checks++; if (wen !== 4'b0000) begin errors++; $display("FAIL rd_wen: got %b expected 0000", wen); end
   endtask

   task automatic test_byte_write();
      logic hs; int en, ok; logic [3:0] wen; logic [9:0] ra; logic [31:0] wd, rd;
      run_one(0, 1'b1, 2'd0, 32'h21, 32'h0000AB00, hs, en, ok, wen, ra, wd, rd);
      checks++; if (wen !== 4'b0010) begin errors++; $display("FAIL bw_wen: got %b expected 0010", wen); end
      checks++; if (ra !== 10'd8) begin errors++; $display("FAIL bw_ram_addr: got %0d expected 8", ra); end
      checks++; if (wd !== 32'h0000AB00) begin errors++; $display("FAIL bw_wdata: got %h expected 0000ab00", wd); end
      checks++; if (ok != 3) begin errors++; $display("FAIL bw_ok_cycle: got %0d expected 3", ok); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL bw_rdata: got %h expected 0", rd); end
      run_one(0, 1'b0, 2'd2, 32'h20, 32'h0, hs, en, ok, wen, ra, wd, rd);
      checks++; if (rd !== 32'hC0DEAB08) begin errors++; $display("FAIL bw_readback: got %h expected c0deab08", rd); end
   endtask

   task automatic test_misaligned();
      logic hs; int en, ok; logic [3:0] wen; logic [9:0] ra; logic [31:0] wd, rd;
      run_one(0, 1'b1, 2'd1, 32'h3, 32'hFFFFFFFF, hs, en, ok, wen, ra, wd, rd);
      checks++; if (wen !== 4'b0000) begin errors++; $display("FAIL mis_half_wen: got %b expected 0000", wen); end
      checks++; if (ok != 3) begin errors++; $display("FAIL mis_half_ok: got %0d expected 3", ok); end
      run_one(0, 1'b1, 2'd3, 32'h0C, 32'hFFFFFFFF, hs, en, ok, wen, ra, wd, rd);
      checks++; if (wen !== 4'b0000) begin errors++; $display("FAIL ill_size_wen: got %b expected 0000", wen); end
      checks++; if (ok != 3) begin errors++; $display("FAIL ill_size_ok: got %0d expected 3", ok); end
      run_one(0, 1'b0, 2'd2, 32'h0, 32'h0, hs, en, ok, wen, ra, wd, rd);
      checks++; if (rd !== 32'hC0DE0000) begin errors++; $display("FAIL mis_half_ram: got %h expected c0de0000", rd); end
      run_one(0, 1'b0, 2'd2, 32'h0C, 32'h0, hs, en, ok, wen, ra, wd, rd);
      checks++; if (rd !== 32'hC0DE0003) begin errors++; $display("FAIL ill_size_ram: got %h expected c0de0003", rd); end
      run_one(0, 1'b1, 2'd1, 32'h2A, 32'h12340000, hs, en, ok, wen, ra, wd, rd);
      checks++; if (wen !== 4'b1100) begin errors++; $display("FAIL half_hi_wen: got %b expected 1100", wen); end
      run_one(0, 1'b0, 2'd2, 32'h28, 32'h0, hs, en, ok, wen, ra, wd, rd);
      checks++; if (rd !== 32'h1234000A) begin errors++; $display("FAIL half_hi_ram: got %h expected 1234000a", rd); end
      run_one(0, 1'b0, 2'd2, 32'h12, 32'h0, hs, en, ok, wen, ra, wd, rd);
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_read: got %h expected deadbeef", rd); end
   endtask

   task automatic test_back_to_back();
      int issued = 0;
      int oks = 0;
      int ok_t [5];
      logic [31:0] ok_d [5];
      logic exp_ok;
      for (int cyc = 0; cyc <= 30; cyc++) begin
         @(negedge clk);
         req[1] = (issued < 5); wr[1] = 1'b0; size[1] = 2'd2;
         addr[1] = 32'h40 + 32'(issued * 4); wdata[1] = '0;
         #1;
         if (cyc <= 6) begin
            exp_ok = (cyc < 4) || (cyc == 6);
            checks++;
            if (addr_ok[1] !== exp_ok) begin
               errors++; $display("FAIL b2b_addr_ok cyc %0d: got %b expected %b", cyc, addr_ok[1], exp_ok);
            end
         end
         if (req[1] && addr_ok[1]) issued++;
         if (data_ok[1]) begin
            if (oks < 5) begin ok_t[oks] = cyc; ok_d[oks] = rdata[1]; end
            oks++;
         end
      end
      req[1] = 1'b0;
      checks++; if (oks != 5) begin errors++; $display("FAIL b2b_resp_count: got %0d expected 5", oks); end
      for (int i = 0; i < 5 && i < oks; i++) begin
         checks++;
         if (ok_t[i] != 5 + 4 * i) begin
            errors++; $display("FAIL b2b_ok_cycle[%0d]: got %0d expected %0d", i, ok_t[i], 5 + 4 * i);
         end
         checks++;
         if (ok_d[i] !== 32'hC0DE0010 + 32'(i)) begin
            errors++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", i, ok_d[i], 32'hC0DE0010 + 32'(i));
         end
      end
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      logic hs; int en, ok; logic [3:0] wen; logic [9:0] ra; logic [31:0] wd, rd;
      for (int c = 0; c <= 4; c++) begin
         @(negedge clk);
         req[1] = (c < 3); wr[1] = 1'b0; size[1] = 2'd2; addr[1] = 32'h50 + 32'(4 * c);
         #1;
      end
      checks++; if (ram_en[1] !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_en: got %b expected 1", ram_en[1]); end
      #1;
      rstn = 1'b0;
      req[1] = 1'b1;
      #1;
      checks++;
      if ({addr_ok[1], data_ok[1], ram_en[1]} !== 3'b000) begin
         errors++; $display("FAIL rst_mid_ctrl: got %b expected 000", {addr_ok[1], data_ok[1], ram_en[1]});
      end
      checks++;
      if ({rdata[1], ram_wen[1], ram_addr[1], ram_wdata[1]} !== 78'h0) begin
         errors++; $display("FAIL rst_mid_data: got %h expected 0", {rdata[1], ram_wen[1], ram_addr[1], ram_wdata[1]});
      end
      req[1] = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         #1;
         if (data_ok[1]) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL rst_mid_stale_ok: got %0d expected 0", seen); end
      run_one(1, 1'b0, 2'd2, 32'h60, 32'h0, hs, en, ok, wen, ra, wd, rd);
      checks++; if (ok != 5) begin errors++; $display("FAIL rst_mid_fresh_ok: got %0d expected 5", ok); end
      checks++; if (rd !== 32'hC0DE0018) begin errors++; $display("FAIL rst_mid_fresh_data: got %h expected c0de0018", rd); end
   endtask

   initial begin
      test_reset();
      test_word_read();
      test_byte_write();
      test_misaligned();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
